// File: rtl/dac_window_sequencer.sv
// ---------------------------------------------------------------------------
// dac_window_sequencer
//
// Consumer side of the DAC_advance interface for one DAC channel. Counts
// consecutive DAC_advance assertions through the IDLE -> TRACK -> STIM window
// sequence. The current window index is fed back to the advance logic on
// DAC_fsm_state_counter. Passing the last window fires a one-cycle stim
// trigger. An optional programmable refractory hold-off follows each stim.
//
// Optional feature macro: DAC_SEQ_STATS_EN
//   When defined, the block adds saturating 16-bit stim and abort counters.
//   These counters are cleared only by reset_n.
//   When undefined, those ports and counters do not exist and the core
//   behaviour is unchanged.
//
// Ports
//   dataclk                in   1          system clock, posedge
//   reset_n                in   1          async active-low reset
//   DAC_seq_en             in   1          enable; low flushes to IDLE
//   DAC_advance            in   1          window condition met this cycle
//   DAC_stop_max           in   CNT_WIDTH  index of last window
//   DAC_refractory         in   REF_WIDTH  hold-off cycles after stim
//   DAC_fsm_state_counter  out  CNT_WIDTH  current window index
//   DAC_stim_trigger       out  1          one-cycle stim pulse (state STIM)
//   DAC_seq_state          out  2          0 IDLE, 1 TRACK, 2 STIM, 3 REFRACT
//   DAC_seq_busy           out  1          state != IDLE
//   DAC_stim_count         out  16         (stats) STIM entries, saturating
//   DAC_abort_count        out  16         (stats) TRACK aborts, saturating
// ---------------------------------------------------------------------------
module dac_window_sequencer #(
    parameter int CNT_WIDTH = 32,
    parameter int REF_WIDTH = 16
) (
    input  logic                 dataclk,
    input  logic                 reset_n,
    input  logic                 DAC_seq_en,
    input  logic                 DAC_advance,
    input  logic [CNT_WIDTH-1:0] DAC_stop_max,
    input  logic [REF_WIDTH-1:0] DAC_refractory,
    output logic [CNT_WIDTH-1:0] DAC_fsm_state_counter,
    output logic                 DAC_stim_trigger,
    output logic [1:0]           DAC_seq_state,
    output logic                 DAC_seq_busy
`ifdef DAC_SEQ_STATS_EN
    ,
    output logic [15:0]          DAC_stim_count,
    output logic [15:0]          DAC_abort_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        STIM    = 2'd2,
        REFRACT = 2'd3
    } seq_state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REF_WIDTH-1:0] REF_ONE = {{(REF_WIDTH-1){1'b0}}, 1'b1};

    seq_state_t           state;
    seq_state_t           state_next;
    logic [CNT_WIDTH-1:0] counter;
    logic [CNT_WIDTH-1:0] counter_next;
    logic [REF_WIDTH-1:0] ref_cnt;
    logic [REF_WIDTH-1:0] ref_cnt_next;

    // State, window counter and refractory down-counter registers.
    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            counter <= '0;
            ref_cnt <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            ref_cnt <= ref_cnt_next;
        end
    end

    // Next-state logic. A low enable overrides every transition.
    // The >= compare in TRACK makes a lowered stop_max end the sequence at
    // the next advance. Because of that compare, the counter never wraps.
    // The refractory load is length-1, so REFRACT lasts exactly
    // DAC_refractory cycles.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        ref_cnt_next = ref_cnt;
        if (!DAC_seq_en) begin
            state_next   = IDLE;
            counter_next = '0;
            ref_cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    counter_next = '0;
                    ref_cnt_next = '0;
                    if (DAC_advance) begin
                        if (DAC_stop_max == '0) begin
                            state_next = STIM;
                        end else begin
                            state_next   = TRACK;
                            counter_next = CNT_ONE;
                        end
                    end
                end
                TRACK: begin
                    if (DAC_advance) begin
                        if (counter >= DAC_stop_max) begin
                            state_next   = STIM;
                            counter_next = '0;
                        end else begin
                            counter_next = counter + CNT_ONE;
                        end
                    end else begin
                        state_next   = IDLE;
                        counter_next = '0;
                    end
                end
                STIM: begin
                    counter_next = '0;
                    if (DAC_refractory == '0) begin
                        state_next   = IDLE;
                        ref_cnt_next = '0;
                    end else begin
                        state_next   = REFRACT;
                        ref_cnt_next = DAC_refractory - REF_ONE;
                    end
                end
                REFRACT: begin
                    counter_next = '0;
                    if (ref_cnt == '0) begin
                        state_next = IDLE;
                    end else begin
                        ref_cnt_next = ref_cnt - REF_ONE;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    counter_next = '0;
                    ref_cnt_next = '0;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state and counter flops.
    always_comb begin
        DAC_seq_state         = state;
        DAC_stim_trigger      = (state == STIM);
        DAC_seq_busy          = (state != IDLE);
        DAC_fsm_state_counter = counter;
    end

`ifdef DAC_SEQ_STATS_EN
    logic stim_entry;
    logic abort_event;

    // A stim entry is a transition into STIM. An abort is TRACK dropping
    // advance while enabled. Flush-driven exits do not count as aborts.
    always_comb begin
        stim_entry  = (state_next == STIM) && (state != STIM);
        abort_event = DAC_seq_en && (state == TRACK) && !DAC_advance;
    end

    // Saturating event counters. Only reset_n clears them; a flush does not.
    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            DAC_stim_count  <= '0;
            DAC_abort_count <= '0;
        end else begin
            if (stim_entry && (DAC_stim_count != 16'hFFFF)) begin
                DAC_stim_count <= DAC_stim_count + 16'd1;
            end
            if (abort_event && (DAC_abort_count != 16'hFFFF)) begin
                DAC_abort_count <= DAC_abort_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dac_window_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dac_window_sequencer
//
// Scoreboard bench for dac_window_sequencer.
// applyStimulus drives one cycle of inputs. It also queues the hand-computed
// state and counter expected after the next posedge. A separate monitor
// pops one entry on every negedge and compares it.
// The async reset is checked directly, mid-cycle.
// ---------------------------------------------------------------------------
module tb_dac_window_sequencer;

    localparam int CNT_WIDTH = 32;
    localparam int REF_WIDTH = 16;

    logic                 dataclk;
    logic                 reset_n;
    logic                 DAC_seq_en;
    logic                 DAC_advance;
    logic [CNT_WIDTH-1:0] DAC_stop_max;
    logic [REF_WIDTH-1:0] DAC_refractory;
    logic [CNT_WIDTH-1:0] DAC_fsm_state_counter;
    logic                 DAC_stim_trigger;
    logic [1:0]           DAC_seq_state;
    logic                 DAC_seq_busy;
`ifdef DAC_SEQ_STATS_EN
    logic [15:0]          DAC_stim_count;
    logic [15:0]          DAC_abort_count;
`endif

    typedef struct {
        string name;
        int    st;
        int    cnt;
    } exp_t;

    exp_t expQ[$];
    int   testsRun;
    int   testsFailed;

    dac_window_sequencer #(
        .CNT_WIDTH(CNT_WIDTH),
        .REF_WIDTH(REF_WIDTH)
    ) dut (
        .dataclk              (dataclk),
        .reset_n              (reset_n),
        .DAC_seq_en           (DAC_seq_en),
        .DAC_advance          (DAC_advance),
        .DAC_stop_max         (DAC_stop_max),
        .DAC_refractory       (DAC_refractory),
        .DAC_fsm_state_counter(DAC_fsm_state_counter),
        .DAC_stim_trigger     (DAC_stim_trigger),
        .DAC_seq_state        (DAC_seq_state),
        .DAC_seq_busy         (DAC_seq_busy)
`ifdef DAC_SEQ_STATS_EN
        ,
        .DAC_stim_count       (DAC_stim_count),
        .DAC_abort_count      (DAC_abort_count)
`endif
    );

    // 10 ns clock
    initial begin
        dataclk = 1'b0;
        forever #5 dataclk = ~dataclk;
    end

    // Compare all outputs against the expected state and counter.
    // The trigger must be high exactly in STIM (2).
    // Busy must be high in any state other than IDLE (0).
    task automatic checkOutput(input string name, input int st, input int cnt);
        logic [1:0]           expSt;
        logic [CNT_WIDTH-1:0] expCnt;
        logic                 expTrig;
        logic                 expBusy;
        expSt   = st[1:0];
        expCnt  = CNT_WIDTH'(cnt);
        expTrig = (st == 2);
        expBusy = (st != 0);
        testsRun++;
        if (DAC_seq_state !== expSt || DAC_fsm_state_counter !== expCnt ||
            DAC_stim_trigger !== expTrig || DAC_seq_busy !== expBusy) begin
            testsFailed++;
            $display("[TB] FAIL %s: got state=%0d cnt=%0d trig=%0b busy=%0b, expected state=%0d cnt=%0d trig=%0b busy=%0b",
                     name, DAC_seq_state, DAC_fsm_state_counter, DAC_stim_trigger, DAC_seq_busy,
                     expSt, expCnt, expTrig, expBusy);
        end
    endtask

    // Drive one cycle of inputs, then queue the outputs expected after the edge.
    task automatic applyStimulus(input string name, input logic en, input logic adv,
                                 input int st, input int cnt);
        exp_t e;
        DAC_seq_en  = en;
        DAC_advance = adv;
        e.name = name;
        e.st   = st;
        e.cnt  = cnt;
        expQ.push_back(e);
        @(posedge dataclk);
        @(negedge dataclk);
    endtask

`ifdef DAC_SEQ_STATS_EN
    task automatic checkStats(input string name, input int stims, input int aborts);
        testsRun++;
        if (DAC_stim_count !== 16'(stims) || DAC_abort_count !== 16'(aborts)) begin
            testsFailed++;
            $display("[TB] FAIL %s: got stim=%0d abort=%0d, expected stim=%0d abort=%0d",
                     name, DAC_stim_count, DAC_abort_count, stims, aborts);
        end
    endtask
`endif

    // Monitor: one scoreboard entry per cycle, checked on the negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge dataclk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e.name, e.st, e.cnt);
            end
        end
    end

    initial begin
        testsRun       = 0;
        testsFailed    = 0;
        reset_n        = 1'b0;
        DAC_seq_en     = 1'b0;
        DAC_advance    = 1'b0;
        DAC_stop_max   = '0;
        DAC_refractory = '0;

        #3;
        checkOutput("reset_state", 0, 0);
        @(negedge dataclk);
        reset_n = 1'b1;
        @(negedge dataclk);

        // 1: stop_max=5, advance held, with no refractory
        DAC_stop_max   = 5;
        DAC_refractory = 0;
        applyStimulus("t1_c1", 1, 1, 1, 1);
        applyStimulus("t1_c2", 1, 1, 1, 2);
        applyStimulus("t1_c3", 1, 1, 1, 3);
        applyStimulus("t1_c4", 1, 1, 1, 4);
        applyStimulus("t1_c5", 1, 1, 1, 5);
        applyStimulus("t1_stim", 1, 1, 2, 0);
        applyStimulus("t1_idle", 1, 1, 0, 0);
        applyStimulus("t1_restart", 1, 1, 1, 1);
        applyStimulus("t1_abort", 1, 0, 0, 0);

        // 2: abort after three advances
        applyStimulus("t2_c1", 1, 1, 1, 1);
        applyStimulus("t2_c2", 1, 1, 1, 2);
        applyStimulus("t2_c3", 1, 1, 1, 3);
        applyStimulus("t2_abort", 1, 0, 0, 0);
        applyStimulus("t2_idle", 1, 0, 0, 0);

        // 3: stop_max=0, single pulse goes straight to STIM
        DAC_stop_max = 0;
        applyStimulus("t3_stim", 1, 1, 2, 0);
        applyStimulus("t3_idle", 1, 0, 0, 0);
        applyStimulus("t3_stay", 1, 0, 0, 0);

        // 4: stop_max=2, refractory=4. A refractory change mid-hold is ignored.
        DAC_stop_max   = 2;
        DAC_refractory = 4;
        applyStimulus("t4_c1", 1, 1, 1, 1);
        applyStimulus("t4_c2", 1, 1, 1, 2);
        applyStimulus("t4_stim", 1, 1, 2, 0);
        applyStimulus("t4_ref1", 1, 1, 3, 0);
        DAC_refractory = 9;
        applyStimulus("t4_ref2", 1, 1, 3, 0);
        applyStimulus("t4_ref3", 1, 1, 3, 0);
        applyStimulus("t4_ref4", 1, 1, 3, 0);
        applyStimulus("t4_idle", 1, 1, 0, 0);
        applyStimulus("t4_track", 1, 1, 1, 1);
        DAC_refractory = 0;
        applyStimulus("t4_abort", 1, 0, 0, 0);

        // 5: stop_max lowered below the counter mid-sequence
        DAC_stop_max = 10;
        for (int i = 1; i <= 7; i++) begin
            applyStimulus($sformatf("t5_c%0d", i), 1, 1, 1, i);
        end
        DAC_stop_max = 3;
        applyStimulus("t5_stim", 1, 1, 2, 0);
        applyStimulus("t5_idle", 1, 0, 0, 0);
`ifdef DAC_SEQ_STATS_EN
        checkStats("stats_pre_reset", 4, 3);
`endif

        // 6a: async reset mid-TRACK with counter=4
        DAC_stop_max = 5;
        applyStimulus("t6_c1", 1, 1, 1, 1);
        applyStimulus("t6_c2", 1, 1, 1, 2);
        applyStimulus("t6_c3", 1, 1, 1, 3);
        applyStimulus("t6_c4", 1, 1, 1, 4);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_async_reset", 0, 0);
`ifdef DAC_SEQ_STATS_EN
        checkStats("stats_reset", 0, 0);
`endif
        @(negedge dataclk);
        reset_n = 1'b1;

        // 6b: flush while in REFRACT and while in STIM
        DAC_stop_max   = 0;
        DAC_refractory = 3;
        applyStimulus("t6_stim", 1, 1, 2, 0);
        applyStimulus("t6_ref1", 1, 1, 3, 0);
        applyStimulus("t6_ref2", 1, 1, 3, 0);
        applyStimulus("t6_flush_ref", 0, 1, 0, 0);
        applyStimulus("t6_flush_hold", 0, 1, 0, 0);
        applyStimulus("t6_stim2", 1, 1, 2, 0);
        applyStimulus("t6_flush_stim", 0, 1, 0, 0);
        applyStimulus("t6_idle", 1, 0, 0, 0);

        // Let the monitor drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
            @(negedge dataclk);
        end
        if (expQ.size() > 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", expQ.size());
        end
`ifdef DAC_SEQ_STATS_EN
        checkStats("stats_final", 2, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
